mips_cpu_muldiv: RTL and testbench

Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair for the MIPS core. It executes MULT, MULTU, DIV and DIVU iteratively, one bit per enabled cycle, and services MTHI/MTLO writes. It exposes a start/busy/done handshake so the CPU state machine can stall MFHI/MFLO until results are valid. It sits beside the ALU and register file inside the CPU; HI/LO are read directly by the core.

---
 rtl/mips_cpu_muldiv.sv | 182 ++++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS multiply/divide unit that owns the HI/LO pair.
// It resolves one bit per enabled cycle and then applies a sign fix-up in one more cycle.
module mips_cpu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, remd;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = done_q;

    signed_op = ~op[0];
    a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

    // Shift-add step (multiply) and restoring step (divide)
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};

    prod = neg_q  ? -acc_q : acc_q;
    quot = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remd = rneg_q ? -rem_q : rem_q;

    if (clk_enable) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !cancel) begin
            state_d  = RUN;
            busy_d   = 1'b1;
            cnt_d    = '0;
            is_div_d = op[1];
            a_d      = a;
            bzero_d  = (b == '0);
            neg_d    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d   = signed_op & a[WIDTH-1];
            rem_d    = '0;
            if (op[1]) begin
              acc_d  = {{WIDTH{1'b0}}, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, b_mag};
              opnd_d = a_mag;
            end
          end else begin
            if (mthi) hi_d = a;
            if (mtlo) lo_d = a;
          end
        end
        RUN: begin
          if (cancel) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            cnt_d = CW'(cnt_q + 1'b1);
            if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            if (is_div_q) begin
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
              rem_d = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
            end else begin
              acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (!cancel) begin
            done_d = 1'b1;
            if (!is_div_q) begin
              {hi_d, lo_d} = prod;
            end else if (bzero_q) begin
              hi_d = a_q;
              lo_d = {WIDTH{1'b1}};
            end else begin
              hi_d = remd;
              lo_d = quot;
            end
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed testbench for mips_cpu_muldiv.
// It applies a table of operations back-to-back, then runs hand sequences for mthi/mtlo, cancel, enable stalls and reset.
module tb_mips_cpu_muldiv;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, clk_enable, start, mthi, mtlo, cancel;
  logic [1:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs [12];

  mips_cpu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .cancel(cancel),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts an operation and waits for done; lat counts edges after the accept edge.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        output int lat, output int bcnt);
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 0;
    bcnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy === 1'b1) bcnt++;
    end
  endtask

  initial begin
    int lat, bcnt, seen;
    logic [W-1:0] hi_gap;
    logic busy_gap;

    vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[4]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[5]  = '{2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[6]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[8]  = '{2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F};
    vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[10] = '{2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[11] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

    reset = 1'b0; clk_enable = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; cancel = 1'b0;
    op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    reset = 1'b1;
    @(posedge clk); #1;

    // mthi in IDLE
    mthi = 1'b1; a = 32'hAAAA5555;
    @(posedge clk); #1;
    mthi = 1'b0;
    chk("mthi_hi", hi, 32'hAAAA5555);

    // MULTU 3*5 with mtlo and a second start during busy, both ignored
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b1; mtlo = 1'b1; op = 2'b10; a = 32'hDEAD; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_lat", W'(lat), 32'd33);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd15);
    chk("b2b_done_high", W'(done), 32'd1);

    // Table of operations, each started while the previous done is high
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      chk($sformatf("v%0d_lat", i), W'(lat), 32'd33);
      chk($sformatf("v%0d_busy", i), W'(bcnt), 32'd33);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
    end

    // mthi then mtlo, then cancel DIVU 100/7 at iteration 10
    mthi = 1'b1; a = 32'h5678;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b1; a = 32'h1234;
    @(posedge clk); #1;
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'h1234);
    chk("mthi2_hi", hi, 32'h5678);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_busy", W'(busy), '0);
    chk("cancel_done", W'(done), '0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    chk("cancel_no_done", W'(seen), '0);
    chk("cancel_lo", lo, 32'h1234);
    chk("cancel_hi", hi, 32'h5678);

    // MULT with clk_enable low for 5 cycles mid-operation
    start = 1'b1; op = 2'b00; a = 32'hFFFFFFFE; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; hi_gap = '0; busy_gap = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      clk_enable = !(lat >= 10 && lat < 15);
      @(posedge clk); #1;
      lat++;
      if (lat == 15) begin
        hi_gap = hi;
        busy_gap = busy;
      end
    end
    clk_enable = 1'b1;
    chk("en_lat", W'(lat), 32'd38);
    chk("en_gap_hi", hi_gap, 32'h5678);
    chk("en_gap_busy", W'(busy_gap), 32'd1);
    chk("en_hi", hi, 32'hFFFFFFFF);
    chk("en_lo", lo, 32'hFFFFFFFA);

    // Asynchronous reset at iteration 20
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_hi", hi, '0);
    chk("arst_lo", lo, '0);
    chk("arst_busy", W'(busy), '0);
    chk("arst_done", W'(done), '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", W'(busy), '0);
    run_op(2'b01, 32'd3, 32'd5, lat, bcnt);
    chk("post_rst_lat", W'(lat), 32'd33);
    chk("post_rst_lo", lo, 32'd15);
    chk("post_rst_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
